multicycle_main_control_fsm: RTL and testbench

//  Main control sequencer for the multicycle MIPS datapath. Decodes the opcode and steps each instruction

---
 rtl/multicycle_main_control_fsm_pkg.sv | 58 +++++
 rtl/multicycle_main_control_fsm_if.sv | 37 +++
 rtl/multicycle_main_control_fsm_ctrl_out_decode.sv | 60 ++++++
 rtl/multicycle_main_control_fsm.sv | 77 +++++++
 tb/tb_multicycle_main_control_fsm.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS main control sequencer:
// opcodes, ALUOp/select codes, state encodings and the control-word layout.
package multicycle_main_control_fsm_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    ADDI_EX   = 4'd9,
    ADDI_WB   = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_fsm_if.sv
// Control bus between the main sequencer (master) and the datapath (slave).
interface multicycle_main_control_fsm_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ALUOp;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
           pc_source, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
           pc_source, illegal_op, state_dbg
  );

endinterface

// File: rtl/multicycle_main_control_fsm_ctrl_out_decode.sv
// Combinational state + mem_ready -> control-word decoder.
// FETCH is the only Mealy state: IR and PC load only once memory delivers.
module mips_ctrl_out_decode
  import multicycle_main_control_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      MEM_ADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ADDI_WB: ctrl.reg_write = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control_fsm.sv
// Main control sequencer for the multicycle MIPS datapath: state register,
// opcode-driven next-state logic and the sticky illegal-opcode trap flag.
module multicycle_main_control_fsm
  import multicycle_main_control_fsm_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  multicycle_main_control_fsm_if.master bus
);

  state_t state;
  state_t next_state;
  logic   illegal_op;
  ctrl_t  ctrl;

  // illegal_op rises together with the entry into TRAP so it is visible in TRAP itself
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      illegal_op <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == TRAP) illegal_op <= 1'b1;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    next_state = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_R:         next_state = EXECUTE;
          OP_ADDI:      next_state = ADDI_EX;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          default:      next_state = TRAP;
        endcase
      end
      MEM_ADDR:  next_state = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next_state = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: next_state = bus.mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   next_state = R_WB;
      ADDI_EX:   next_state = ADDI_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: next_state = FETCH;
      TRAP:      next_state = TRAP;
      default:   next_state = IDLE;
    endcase
  end

  mips_ctrl_out_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    bus.pc_write      = ctrl.pc_write;
    bus.pc_write_cond = ctrl.pc_write_cond;
    bus.iord          = ctrl.iord;
    bus.mem_read      = ctrl.mem_read;
    bus.mem_write     = ctrl.mem_write;
    bus.ir_write      = ctrl.ir_write;
    bus.mem_to_reg    = ctrl.mem_to_reg;
    bus.reg_dst       = ctrl.reg_dst;
    bus.reg_write     = ctrl.reg_write;
    bus.alu_src_a     = ctrl.alu_src_a;
    bus.alu_src_b     = ctrl.alu_src_b;
    bus.ALUOp         = ctrl.alu_op;
    bus.pc_source     = ctrl.pc_source;
    bus.illegal_op    = illegal_op;
    bus.state_dbg     = state;
  end

endmodule

// File: tb/tb_multicycle_main_control_fsm.sv
// Self-checking bench: directed scenarios then randomized traffic against an
// instruction-level reference model (per-opcode step plans, stall-aware).
module tb_multicycle_main_control_fsm;
  import multicycle_main_control_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_main_control_fsm_if bus ();

  multicycle_main_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  state_t     m_state = IDLE;
  bit         m_valid = 1'b0;
  bit         m_illegal = 1'b0;
  state_t     plan[$];
  // instruction cycle-count tracking
  bit         active = 1'b0;
  int         cyc_cnt = 0;
  int         stall_cnt = 0;
  logic [5:0] cur_op = OP_R;
  logic [3:0] prev_dbg = 4'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected control word {pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rw,sa,sb,aop,ps}
  function automatic logic [15:0] exp_word(input state_t s, input logic mr);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, ps;
    {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (s)
      FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      DECODE:    sb = 2'b11;
      MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      MEM_READ:  begin mrd = 1; io = 1; end
      MEM_WB:    begin rw = 1; m2r = 1; end
      MEM_WRITE: begin mwr = 1; io = 1; end
      EXECUTE:   begin sa = 1; aop = 2'b10; end
      R_WB:      begin rw = 1; rd = 1; end
      ADDI_EX:   begin sa = 1; sb = 2'b10; end
      ADDI_WB:   rw = 1;
      BRANCH:    begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      JUMP:      begin pw = 1; ps = 2'b10; end
      default:   ;
    endcase
    return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, ps};
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SW: return 4;
      OP_LW:                return 5;
      OP_BEQ, OP_J:         return 3;
      default:              return 0;
    endcase
  endfunction

  task automatic build_plan(input logic [5:0] op);
    plan.delete();
    plan.push_back(DECODE);
    case (op)
      OP_R:    begin plan.push_back(EXECUTE); plan.push_back(R_WB); end
      OP_ADDI: begin plan.push_back(ADDI_EX); plan.push_back(ADDI_WB); end
      OP_LW:   begin plan.push_back(MEM_ADDR); plan.push_back(MEM_READ); plan.push_back(MEM_WB); end
      OP_SW:   begin plan.push_back(MEM_ADDR); plan.push_back(MEM_WRITE); end
      OP_BEQ:  plan.push_back(BRANCH);
      OP_J:    plan.push_back(JUMP);
      default: plan.push_back(TRAP);
    endcase
  endtask

  task automatic advance();
    if (plan.size() > 0) m_state = plan.pop_front();
    else m_state = FETCH;
    if (m_state == TRAP) m_illegal = 1'b1;
  endtask

  // one clock cycle: drive, observe between edges, then step the model
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic mr);
    logic [15:0] obs;
    @(negedge clk);
    rst = r;
    bus.opcode = op;
    bus.zero = z;
    bus.mem_ready = mr;
    #1;
    if (m_valid) begin
      obs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
             bus.alu_src_b, bus.ALUOp, bus.pc_source};
      checkOutput("ctrl_word", 32'(obs), 32'(exp_word(m_state, mr)));
      checkOutput("state_dbg", 32'(bus.state_dbg), 32'(m_state));
      checkOutput("illegal_op", 32'(bus.illegal_op), 32'(m_illegal));
      checkOutput("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (bus.state_dbg == FETCH && prev_dbg != FETCH) begin
        if (active) checkOutput("instr_cycles", cyc_cnt, base_cycles(cur_op) + stall_cnt);
        active = 1'b1;
        cyc_cnt = 0;
        stall_cnt = 0;
      end
      if (active) begin
        cyc_cnt++;
        if (!mr && (m_state == FETCH || m_state == MEM_READ || m_state == MEM_WRITE)) stall_cnt++;
      end
      prev_dbg = bus.state_dbg;
    end
    if (r) begin
      m_state = IDLE;
      m_valid = 1'b1;
      m_illegal = 1'b0;
      plan.delete();
      active = 1'b0;
      prev_dbg = 4'd0;
    end else if (m_valid) begin
      case (m_state)
        IDLE:  m_state = FETCH;
        FETCH: if (mr) begin cur_op = op; build_plan(op); advance(); end
        TRAP:  m_state = TRAP;
        MEM_READ, MEM_WRITE: if (mr) advance();
        default: advance();
      endcase
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, op, z, 1'b1);
  endtask

  logic [5:0] rand_op;
  logic [5:0] ops[6];

  initial begin
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    bus.opcode = OP_R;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    // reset, then IDLE -> FETCH -> DECODE, followed by an R-type instruction
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    run_instr(OP_R, 1'b0, 5);

    // lw with three wait states in MEM_READ
    applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, OP_LW, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);

    run_instr(OP_BEQ, 1'b1, 3);
    run_instr(OP_BEQ, 1'b0, 3);
    run_instr(OP_J, 1'b0, 3);
    run_instr(OP_ADDI, 1'b0, 4);
    run_instr(OP_SW, 1'b0, 4);

    // illegal opcode traps and holds until reset
    run_instr(6'b111111, 1'b0, 2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 6'b111111, 1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);

    // reset in the middle of a stalled store
    run_instr(OP_SW, 1'b0, 3);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SW, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);

    // randomized traffic; opcode only changes while fetching, as the IR would
    rand_op = OP_R;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == FETCH || m_state == IDLE) begin
        if ($urandom_range(0, 19) == 0) rand_op = 6'($urandom);
        else rand_op = ops[$urandom_range(0, 5)];
      end
      applyStimulus(1'($urandom_range(0, 79) == 0), rand_op, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
